// File: rtl/axis_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// axis_mem_responder_pkg
// Shared definitions for the memory-side request responder:
//   - channel_update_t : header carried in bits [54:0] of a tuser=1 request beat
//   - header bit-field positions and widths
//   - FSM state encoding
//   - decode_header()  : extracts a channel_update_t from raw header bits
// -----------------------------------------------------------------------------
package axis_mem_responder_pkg;

    localparam int HDR_W        = 55;
    localparam int HDR_FIELD_W  = 27;
    localparam int HDR_ADDR_LSB = 28;
    localparam int HDR_LEN_LSB  = 1;
    localparam int HDR_WEN_BIT  = 0;

    typedef struct packed {
        logic [HDR_FIELD_W-1:0] addr;
        logic [HDR_FIELD_W-1:0] stream_length;
        logic                   wen;
    } channel_update_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    function automatic channel_update_t decode_header(input logic [HDR_W-1:0] bits);
        channel_update_t hdr;
        hdr.addr          = bits[HDR_ADDR_LSB +: HDR_FIELD_W];
        hdr.stream_length = bits[HDR_LEN_LSB  +: HDR_FIELD_W];
        hdr.wen           = bits[HDR_WEN_BIT];
        return hdr;
    endfunction

endpackage

// File: rtl/axis_mem_responder_resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Synchronous single-clock FIFO holding read-response beats.
// Head data is presented combinationally on o_dout while o_empty is low.
// A push and a pop in the same cycle on a full FIFO are both honoured.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_din     write a beat
//   i_pop             remove the head beat
//   o_dout            head beat
//   o_full, o_empty   occupancy flags
//   o_count           number of stored beats (0..DEPTH)
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == {(AW+1){1'b0}});
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO may still accept a beat when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array write port (no reset needed on data)
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_mem_responder.sv
// -----------------------------------------------------------------------------
// axis_mem_responder
// Memory-side terminus of the processor request stream. A tuser=1 request
// beat carries a channel_update header (addr, stream_length, wen); write
// bursts pass data beats straight through to the memory port, read bursts
// issue credit-limited commands whose data returns through resp_fifo as
// untagged 128-bit response beats.
// Optional build macro: AXIS_MEM_RESPONDER_STATS_EN enables the 32-bit
// stat_reads / stat_writes command counters (tied to zero otherwise).
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   req_axis_*                     request stream (data/tuser/valid/ready)
//   resp_axis_*                    response stream (tuser always 0)
//   mem_addr/wdata/wen/valid/ready in-order word command port
//   mem_rdata/mem_rvalid           in-order, non-stallable read return
//   stat_reads/stat_writes         accepted command counters
//   proto_err                      sticky protocol-error flag
// -----------------------------------------------------------------------------
module axis_mem_responder
    import axis_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int RESP_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] req_axis_data,
    input  logic              req_axis_tuser,
    input  logic              req_axis_valid,
    output logic              req_axis_ready,
    output logic [DATA_W-1:0] resp_axis_data,
    output logic              resp_axis_tuser,
    output logic              resp_axis_valid,
    input  logic              resp_axis_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_valid,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic              proto_err
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_W-1:0]      r_cur, w_cur_nxt;
    logic [HDR_FIELD_W-1:0] r_rem, w_rem_nxt;
    logic [CW-1:0]          r_credits, w_credits_nxt;
    logic                   r_proto_err, w_proto_err_nxt;
    channel_update_t        w_hdr;
    logic                   w_req_ready, w_mem_valid, w_mem_wen;
    logic [DATA_W-1:0]      w_mem_wdata;
    logic                   w_issue, w_pop, w_rd_stray;
    logic                   w_fifo_full, w_fifo_empty;
    logic [CW-1:0]          w_fifo_count;

    // Handshake outputs are forced low while reset is held.
    assign req_axis_ready  = w_req_ready & ~rst_in;
    assign mem_valid       = w_mem_valid & ~rst_in;
    assign mem_wen         = w_mem_wen;
    assign mem_wdata       = w_mem_wdata;
    assign mem_addr        = r_cur;
    assign proto_err       = r_proto_err;
    assign resp_axis_tuser = 1'b0;
    assign resp_axis_valid = ~w_fifo_empty;
    assign w_pop           = resp_axis_valid & resp_axis_ready;
    assign w_issue         = mem_valid & mem_ready & ~mem_wen;

    // Read data with nothing outstanding (or no room) indicates a broken memory side.
    assign w_rd_stray = mem_rvalid &
        ((((CW+1)'(w_fifo_count) + (CW+1)'(r_credits)) == (CW+1)'(RESP_DEPTH)) |
         (w_fifo_full & ~w_pop));

    // FSM next-state, burst datapath and memory-port outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_rem_nxt       = r_rem;
        w_proto_err_nxt = r_proto_err | w_rd_stray;
        w_req_ready     = 1'b0;
        w_mem_valid     = 1'b0;
        w_mem_wen       = 1'b0;
        w_mem_wdata     = {DATA_W{1'b0}};
        w_hdr           = decode_header(req_axis_data[HDR_W-1:0]);
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_axis_valid && req_axis_tuser) begin
                    w_cur_nxt = ADDR_W'(w_hdr.addr);
                    w_rem_nxt = w_hdr.stream_length;
                    if (w_hdr.stream_length == {HDR_FIELD_W{1'b0}}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = w_hdr.wen ? ST_WRITE : ST_READ;
                    end
                end else if (req_axis_valid) begin
                    w_proto_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Data beats are forwarded in the same cycle they are accepted.
                w_req_ready = mem_ready;
                w_mem_wen   = 1'b1;
                w_mem_wdata = req_axis_data;
                w_mem_valid = req_axis_valid & ~req_axis_tuser;
                if (req_axis_valid && mem_ready && req_axis_tuser) begin
                    // Early header aborts the burst and starts the new one.
                    w_proto_err_nxt = 1'b1;
                    w_cur_nxt       = ADDR_W'(w_hdr.addr);
                    w_rem_nxt       = w_hdr.stream_length;
                    if (w_hdr.stream_length == {HDR_FIELD_W{1'b0}}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = w_hdr.wen ? ST_WRITE : ST_READ;
                    end
                end else if (req_axis_valid && mem_ready) begin
                    w_cur_nxt = r_cur + 1'b1;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == {{(HDR_FIELD_W-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WRITE;
                    end
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                w_mem_valid = (r_credits != {CW{1'b0}}) & (r_rem != {HDR_FIELD_W{1'b0}});
                if (w_mem_valid && mem_ready) begin
                    w_cur_nxt = r_cur + 1'b1;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == {{(HDR_FIELD_W-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Credit accounting: a read issue consumes one, a response pop returns one
    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_issue, w_pop})
            2'b10: w_credits_nxt = r_credits - 1'b1;
            2'b01: begin
                if (r_credits < CW'(RESP_DEPTH)) begin
                    w_credits_nxt = r_credits + 1'b1;
                end else begin
                    w_credits_nxt = r_credits;
                end
            end
            default: w_credits_nxt = r_credits;
        endcase
    end

    // FSM state, burst pointers, credits and sticky error flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_cur       <= {ADDR_W{1'b0}};
            r_rem       <= {HDR_FIELD_W{1'b0}};
            r_credits   <= CW'(RESP_DEPTH);
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_rem       <= w_rem_nxt;
            r_credits   <= w_credits_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    resp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (mem_rvalid),
        .i_pop   (w_pop),
        .i_din   (mem_rdata),
        .o_dout  (resp_axis_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

`ifdef AXIS_MEM_RESPONDER_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;

    // Accepted read/write command counters, wrapping at 2^32
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stat_reads  <= 32'd0;
            r_stat_writes <= 32'd0;
        end else begin
            if (mem_valid && mem_ready && !mem_wen) begin
                r_stat_reads <= r_stat_reads + 32'd1;
            end
            if (mem_valid && mem_ready && mem_wen) begin
                r_stat_writes <= r_stat_writes + 32'd1;
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
`else
    assign stat_reads  = 32'd0;
    assign stat_writes = 32'd0;
`endif

endmodule

// File: doc/axis_mem_responder.md
Name: axis_mem_responder

Overview:
Memory-side terminus of the processor request stream. It consumes the 128-bit request AXI-stream: a tuser header beat carrying a channel_update, followed by data beats for writes. It performs word accesses on a simple in-order 128-bit memory port and returns read data as a 128-bit response AXI-stream of untagged beats, which the upstream accumulator packs into 512-bit lines. It sits between the processor wrapper and the DRAM/BRAM controller.

Parameters:
ADDR_W, 27, word address width (one word = 128 bits = 16 B)
DATA_W, 128, stream and memory data width
RESP_DEPTH, 8, response FIFO depth in beats (power of two, >= 2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; synchronous, active-high
req_axis_data  input  DATA_W  request beat; header in bits [54:0] when tuser=1
req_axis_tuser  input  1  beat is a header
req_axis_valid  input  1  request beat valid
req_axis_ready  output  1  request beat accepted
resp_axis_data  output  DATA_W  read response beat
resp_axis_tuser  output  1  always 0
resp_axis_valid  output  1  response beat valid
resp_axis_ready  input  1  downstream accepts response
mem_addr  output  ADDR_W  word address
mem_wdata  output  DATA_W  write data
mem_wen  output  1  1 = write, 0 = read
mem_valid  output  1  command valid
mem_ready  input  1  memory accepts command
mem_rdata  input  DATA_W  read data
mem_rvalid  input  1  read data valid; in order, cannot be stalled
stat_reads  output  32  read commands issued (STATS_EN)
stat_writes  output  32  write commands issued (STATS_EN)
proto_err  output  1  sticky protocol-error flag

Behaviour:
- Clock and reset: single clock clk_in; rst_in is synchronous and active-high.
- Header decode from bits [54:0]: addr = [54:28], len = [27:1], wen = [0].
- Reset values: req_axis_ready=0, resp_axis_valid=0, mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, proto_err=0, stat counters=0. The FIFO is emptied and the credit counter is set to RESP_DEPTH.
- IDLE:
  - req_axis_ready=1.
  - On accept with tuser=1: latch addr/len/wen, set cur=addr and remaining=len. Go to WRITE if wen, else READ. If len==0, stay in IDLE.
  - On accept with tuser=0: drop the beat and set proto_err.
- WRITE:
  - req_axis_ready = mem_ready, so each accepted data beat is a memory command in the same cycle.
  - Same cycle: mem_valid=req_axis_valid, mem_wen=1, mem_addr=cur, mem_wdata=req_axis_data. Combinational pass-through; zero added latency.
  - Per accept: cur<=cur+1 (wraps mod 2^ADDR_W), remaining<=remaining-1. Go to IDLE when remaining hits 0.
  - A tuser=1 beat arriving in WRITE: abort the burst, set proto_err, latch it as a new header in the same cycle, no memory write.
- READ:
  - req_axis_ready=0.
  - mem_valid=1 and mem_wen=0 while credits>0 and remaining>0.
  - On mem_valid&&mem_ready: cur++, remaining--, credits--.
  - Go to IDLE once the last command is accepted. Outstanding data drains via the FIFO; a new header may be taken while it drains.
- Credits:
  - Pop (resp_axis_valid&&resp_axis_ready) returns a credit.
  - Simultaneous issue and pop leave credits unchanged.
  - Credits never exceed RESP_DEPTH.
  - mem_rvalid pushes mem_rdata to the FIFO. Because of credits, a push is never dropped.
- Response stream:
  - resp_axis_valid = FIFO not empty; resp_axis_data = FIFO head.
  - Holds stable under backpressure.
  - Push and pop in the same cycle on a full FIFO are legal.
- Reset mid-operation: abandons the burst and flushes the FIFO. The memory controller shares rst_in, so no stale rvalid follows.

Optional Feature:
- Macro: AXIS_MEM_RESPONDER_STATS_EN.
- Defined:
  - stat_reads and stat_writes increment on each accepted read/write command and wrap at 2^32.
  - proto_err also counts as a sticky flag.
- Undefined: stat_reads and stat_writes are tied to 0 and no counter flops exist. proto_err remains.

Decomposition:
- Shared package: the channel_update struct (addr[26:0], stream_length[26:0], wen) and header bit-field constants. This replaces the ad-hoc `ifndef CHANNEL_UPDATE guard.
- One sub-module, resp_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.

Test Plan:
- Write: header addr=0x40, len=4, wen=1, then beats D0..D3 with mem_ready=1 -> four writes at 0x40..0x43 on consecutive cycles; back to IDLE; resp_axis_valid stays 0.
- Read: header addr=0x100, len=4, wen=0, memory latency 3 -> reads at 0x100..0x103; four resp beats with tuser=0, in order.
- Backpressure: resp_axis_ready=0, RESP_DEPTH=8, header len=12 -> exactly 8 reads issued, then stall; releasing ready completes all 12 with no loss.
- Wrap: header addr=0x7FFFFFE, len=4 -> addresses 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
- Protocol error: header len=4 write, 2 data beats, then a header beat -> proto_err=1, only 2 writes issued, new header executed.
- Reset: rst_in asserted during a read after 2 of 4 beats returned -> the next cycle shows resp_axis_valid=0, credits=8, IDLE, and a later read works; with the macro defined, counters read 0.
